// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle between a fabric master port and a register slave.
interface axil_reg_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8:0]   wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [RESP_WIDTH-1:0]   bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_WIDTH-1:0]   rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: three RW words, a read-only count of completed
// writes, SLVERR for unmapped/unaligned accesses and writes to the counter.
module axil_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  axil_reg_slave_if.slave       s_axi,
  output logic [DATA_WIDTH-1:0] ctrl_out
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  localparam logic [1:0] W_IDLE      = 2'd0;
  localparam logic [1:0] W_HAVE_ADDR = 2'd1;
  localparam logic [1:0] W_HAVE_DATA = 2'd2;
  localparam logic [1:0] W_RESP      = 2'd3;
  localparam logic       R_IDLE      = 1'b0;
  localparam logic       R_DATA      = 1'b1;

  logic [1:0]            w_state;
  logic                  r_state;
  // Holds readies low until the first clock edge after reset release.
  logic                  bus_en;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] regs [3];
  logic [DATA_WIDTH-1:0] wcount;
  logic [RESP_WIDTH-1:0] bresp_q;
  logic [RESP_WIDTH-1:0] rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs, w_hs, ar_hs, w_final;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_off, rd_off;
  logic [DATA_WIDTH-1:0] wr_data, rd_value;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  wr_ok, rd_ok;
  logic                  unused_strb;

  assign s_axi.awready = bus_en && (w_state == W_IDLE || w_state == W_HAVE_DATA);
  assign s_axi.wready  = bus_en && (w_state == W_IDLE || w_state == W_HAVE_ADDR);
  assign s_axi.bvalid  = (w_state == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = bus_en && (r_state == R_IDLE);
  assign s_axi.rvalid  = (r_state == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign ctrl_out      = regs[0];

  // Top strobe bit exists only for bus-port width compatibility.
  assign unused_strb = s_axi.wstrb[STRB_WIDTH];

  assign aw_hs   = s_axi.awvalid && s_axi.awready;
  assign w_hs    = s_axi.wvalid && s_axi.wready;
  assign ar_hs   = s_axi.arvalid && s_axi.arready;
  assign w_final = (w_state == W_IDLE && aw_hs && w_hs) ||
                   (w_state == W_HAVE_ADDR && w_hs) ||
                   (w_state == W_HAVE_DATA && aw_hs);

  // Use the latched half of the write if it arrived earlier, else the live bus.
  assign wr_addr = (w_state == W_HAVE_ADDR) ? awaddr_q : s_axi.awaddr;
  assign wr_data = (w_state == W_HAVE_DATA) ? wdata_q : s_axi.wdata;
  assign wr_strb = (w_state == W_HAVE_DATA) ? wstrb_q : s_axi.wstrb[STRB_WIDTH-1:0];

  // BASE_ADDR is 16-byte aligned, so offset[1:0] equals addr[1:0].
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_off = s_axi.araddr - BASE_ADDR;
  assign wr_ok  = (wr_off[1:0] == 2'b00) && (wr_off[ADDR_WIDTH-1:4] == '0) &&
                  (wr_off[3:2] != 2'd3);
  assign rd_ok  = (rd_off[1:0] == 2'b00) && (rd_off[ADDR_WIDTH-1:4] == '0);

  // Read mux over the register map.
  always_comb begin
    rd_value = wcount;
    case (rd_off[3:2])
      2'd0:    rd_value = regs[0];
      2'd1:    rd_value = regs[1];
      2'd2:    rd_value = regs[2];
      default: rd_value = wcount;
    endcase
  end

  // Enable readies one edge after reset release.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) bus_en <= 1'b0;
    else              bus_en <= 1'b1;
  end

  // Write channel FSM, operand latches, register bank and write counter.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      w_state  <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= '0;
      wcount   <= '0;
      for (int r = 0; r < 3; r++) regs[r] <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (w_final)    w_state <= W_RESP;
          else if (aw_hs) w_state <= W_HAVE_ADDR;
          else if (w_hs)  w_state <= W_HAVE_DATA;
        end
        W_HAVE_ADDR: if (w_hs) w_state <= W_RESP;
        W_HAVE_DATA: if (aw_hs) w_state <= W_RESP;
        default:     if (s_axi.bready) w_state <= W_IDLE;
      endcase
      if (aw_hs) awaddr_q <= s_axi.awaddr;
      if (w_hs) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb[STRB_WIDTH-1:0];
      end
      if (w_final) begin
        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          wcount <= wcount + 1'b1;
          for (int r = 0; r < 3; r++) begin
            if (wr_off[3:2] == 2'(r)) begin
              for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wr_strb[b]) regs[r][b*8 +: 8] <= wr_data[b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  // Read channel FSM; data captured at AR handshake sees pre-write values.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state <= R_DATA;
            rdata_q <= rd_ok ? rd_value : '0;
            rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        default: if (s_axi.rready) r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed scenarios plus randomized
// traffic compared against a map-level model of the register bank.
module tb_axil_reg_slave;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] ctrl_out;

  always #5 clk = ~clk;

  axil_reg_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) bus ();

  axil_reg_slave #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RESP_WIDTH(RW),
    .BASE_ADDR (8'h00)
  ) dut (
    .s_axi_aclk  (clk),
    .s_axi_areset(rst),
    .s_axi       (bus),
    .ctrl_out    (ctrl_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: three RW words plus count of OKAY writes.
  logic [31:0] m_reg [3];
  logic [31:0] m_wcount;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // 0..2 = RW register, 3 = counter, -1 = unmapped or unaligned.
  function automatic int m_index(input logic [7:0] a);
    case (a)
      8'h00:   return 0;
      8'h04:   return 1;
      8'h08:   return 2;
      8'h0C:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int i;
    i = m_index(a);
    if (i < 0) return 32'h0;
    if (i == 3) return m_wcount;
    return m_reg[i];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) m_reg[i] = 32'h0;
    m_wcount = 32'h0;
  endtask

  // Called at #1 after a posedge; returns at #1 after the response handshake edge.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input logic [4:0] strb, input int awd, input int wd,
                          input int hold);
    bit aw_done, w_done, hs_aw, hs_w;
    int cyc, idx;
    logic [2:0] exp_resp;
    aw_done = 0;
    w_done  = 0;
    cyc     = 0;
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    while (!(aw_done && w_done)) begin
      if (cyc > 20) begin
        check("wr_handshake_timeout", 0, 1);
        bus.awvalid = 0;
        bus.wvalid  = 0;
        return;
      end
      bus.awvalid = !aw_done && (cyc >= awd);
      bus.wvalid  = !w_done && (cyc >= wd);
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      @(posedge clk);
      #1;
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done  = 1;
      cyc++;
    end
    bus.awvalid = 0;
    bus.wvalid  = 0;
    idx = m_index(addr);
    exp_resp = (idx >= 0 && idx <= 2) ? 3'd0 : 3'd2;
    if (exp_resp == 3'd0) begin
      for (int b = 0; b < 4; b++) if (strb[b]) m_reg[idx][b*8 +: 8] = data[b*8 +: 8];
      m_wcount = m_wcount + 1;
    end
    check("bvalid", bus.bvalid, 1);
    check("bresp", bus.bresp, exp_resp);
    check("ctrl_out", ctrl_out, m_reg[0]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("bvalid_hold", bus.bvalid, 1);
      check("bresp_hold", bus.bresp, exp_resp);
      check("awready_hold", bus.awready, 0);
      check("wready_hold", bus.wready, 0);
    end
    bus.bready = 1;
    @(posedge clk);
    #1;
    bus.bready = 0;
    check("bvalid_drop", bus.bvalid, 0);
    check("awready_back", bus.awready, 1);
  endtask

  task automatic do_read(input logic [7:0] addr, input int ard, input int hold);
    bit done, hs;
    int cyc;
    logic [31:0] exp_data;
    logic [2:0] exp_resp;
    done = 0;
    cyc  = 0;
    bus.araddr = addr;
    exp_data = m_read(addr);
    exp_resp = (m_index(addr) >= 0) ? 3'd0 : 3'd2;
    while (!done) begin
      if (cyc > 20) begin
        check("rd_handshake_timeout", 0, 1);
        bus.arvalid = 0;
        return;
      end
      bus.arvalid = (cyc >= ard);
      hs = bus.arvalid && bus.arready;
      @(posedge clk);
      #1;
      if (hs) done = 1;
      cyc++;
    end
    bus.arvalid = 0;
    check("rvalid", bus.rvalid, 1);
    check("rdata", bus.rdata, exp_data);
    check("rresp", bus.rresp, exp_resp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("rdata_hold", bus.rdata, exp_data);
      check("arready_hold", bus.arready, 0);
    end
    bus.rready = 1;
    @(posedge clk);
    #1;
    bus.rready = 0;
    check("rvalid_drop", bus.rvalid, 0);
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'h04;
      2:       return 8'h08;
      3:       return 8'h0C;
      4:       return 8'h20;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
    m_reset();

    // Reset state and ready rise on the first edge after release.
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", bus.awready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_ctrl_out", ctrl_out, 0);
    rst = 0;
    #1;
    check("pre_edge_wready", bus.wready, 0);
    @(posedge clk);
    #1;
    check("post_rel_awready", bus.awready, 1);
    check("post_rel_wready", bus.wready, 1);
    check("post_rel_arready", bus.arready, 1);

    // Basic write/read, counter.
    do_write(8'h04, 32'hDEADBEEF, 5'h0F, 0, 0, 0);
    do_read(8'h04, 0, 0);
    do_read(8'h0C, 0, 0);
    // Data three cycles ahead of address, partial strobes.
    do_write(8'h00, 32'h12345678, 5'h05, 3, 0, 0);
    check("reg0_partial", ctrl_out, 32'h00340078);
    // Error cases.
    do_write(8'h0C, 32'hFFFFFFFF, 5'h0F, 0, 0, 0);
    do_write(8'h20, 32'h1, 5'h0F, 0, 1, 0);
    do_write(8'h02, 32'h2, 5'h0F, 1, 0, 0);
    do_read(8'h0C, 0, 0);
    do_read(8'h20, 0, 0);
    do_read(8'h02, 0, 0);
    // Back-pressure on B.
    do_write(8'h08, 32'h11, 5'h0F, 0, 0, 5);

    // Same-cycle read and final write handshake to REG2.
    bus.awaddr = 8'h08; bus.wdata = 32'hAAAA5555; bus.wstrb = 5'h0F;
    bus.araddr = 8'h08;
    bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
    @(posedge clk);
    #1;
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    check("race_rdata", bus.rdata, 32'h11);
    check("race_bvalid", bus.bvalid, 1);
    check("race_rvalid", bus.rvalid, 1);
    m_reg[2] = 32'hAAAA5555;
    m_wcount = m_wcount + 1;
    bus.bready = 1; bus.rready = 1;
    @(posedge clk);
    #1;
    bus.bready = 0; bus.rready = 0;
    do_read(8'h08, 0, 0);

    // Randomized mixed traffic.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(pick_addr(), $urandom, 5'($urandom_range(0, 31)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(pick_addr(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset while in W_HAVE_ADDR and R_DATA.
    do_write(8'h00, 32'hCAFEF00D, 5'h0F, 0, 0, 0);
    bus.awaddr = 8'h04; bus.awvalid = 1; bus.araddr = 8'h00; bus.arvalid = 1;
    @(posedge clk);
    #1;
    bus.awvalid = 0; bus.arvalid = 0;
    check("mid_wready", bus.wready, 1);
    check("mid_rvalid", bus.rvalid, 1);
    rst = 1;
    #1;
    check("arst_awready", bus.awready, 0);
    check("arst_wready", bus.wready, 0);
    check("arst_arready", bus.arready, 0);
    check("arst_bvalid", bus.bvalid, 0);
    check("arst_rvalid", bus.rvalid, 0);
    check("arst_bresp", bus.bresp, 0);
    check("arst_rresp", bus.rresp, 0);
    check("arst_rdata", bus.rdata, 0);
    check("arst_ctrl_out", ctrl_out, 0);
    @(posedge clk);
    #1;
    rst = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("post_arst_bvalid", bus.bvalid, 0);
    check("post_arst_rvalid", bus.rvalid, 0);
    do_read(8'h00, 0, 0);
    do_read(8'h04, 0, 0);
    do_read(8'h08, 0, 0);
    do_read(8'h0C, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/axil_reg_slave.md
# axil_reg_slave

AXI4-Lite register-bank slave that sits directly downstream of the bus fabric, on one of its master-side ports, and terminates write and read transactions routed to it. It holds three read/write word registers and one read-only counter of completed writes. Transactions to unmapped or unaligned addresses, and writes to the read-only register, get an error response. Register 0 is also exported as a control word for local logic.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus and register width
- ADDR_WIDTH, 8, address width
- RESP_WIDTH, 3, response width; OKAY = 0, SLVERR = 2
- BASE_ADDR, 0, byte address of register 0; must be 16-byte aligned

Ports:
- s_axi_aclk  in  1  single clock; all logic on rising edge
- s_axi_areset  in  1  reset, asynchronous, active-high
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8+1  byte strobes; bit i enables byte i; top bit ignored (bus-port width compatibility)
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  RESP_WIDTH  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  RESP_WIDTH  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- ctrl_out  out  DATA_WIDTH  current value of REG0

## Operation
- Map, offset = addr − BASE_ADDR:
  - 0x0 REG0 RW
  - 0x4 REG1 RW
  - 0x8 REG2 RW
  - 0xC WCOUNT RO
- Any other offset, or addr[1:0] ≠ 0, is an error → SLVERR.
- Write FSM states:
  - W_IDLE: awready = wready = 1.
  - W_HAVE_ADDR: AW latched; awready = 0, wready = 1.
  - W_HAVE_DATA: W latched; awready = 1, wready = 0.
  - W_RESP: awready = wready = 0; bvalid = 1.
- AW and W are accepted in either order or in the same cycle. Each is latched on its own handshake.
- When both are held, the edge of the final handshake does three things:
  - decodes the address;
  - updates the register, per byte: byte i ← wdata byte i where wstrb[i] = 1;
  - moves to W_RESP.
- A decode error or a write to WCOUNT leaves all registers unchanged and returns bresp = SLVERR. Otherwise bresp = OKAY.
- WCOUNT increments by 1, modulo 2^DATA_WIDTH, on every OKAY write (0xFFFFFFFF → 0). It does not increment on SLVERR.
- W_RESP → W_IDLE on bvalid && bready.
- Read FSM states:
  - R_IDLE: arready = 1.
  - R_DATA: arready = 0; rvalid = 1.
- On an AR handshake, rdata and rresp are captured: register value and OKAY, or 0 and SLVERR. The FSM moves to R_DATA.
- R_DATA → R_IDLE on rvalid && rready.
- Read and write FSMs are independent and may be active at the same time.

## Timing
- While s_axi_areset = 1, asynchronously: all ready/valid outputs = 0, bresp = rresp = 0, rdata = 0, REG0–2 = 0, WCOUNT = 0, ctrl_out = 0, both FSMs idle.
- awready, wready and arready rise at the first rising edge after reset release.
- Reset asserted mid-transaction aborts it. No response is issued afterward.
- Write latency: bvalid is high in the cycle after the final AW/W handshake. The register's new value is visible on ctrl_out and to reads from that same cycle.
- Read latency: rvalid is high in the cycle after the AR handshake.
- bvalid/bresp and rvalid/rdata/rresp are held stable until their handshake completes. With bready or rready held at 1, the next transaction is accepted the cycle after the response handshake.
- Simultaneous AR and final write handshake to the same register in one cycle: the read returns the pre-write value.
- Throughput is at most one write per 2 cycles and one read per 2 cycles.

## Test plan
- Reset, then write 0xDEADBEEF to 0x04 with wstrb = 0xF, AW and W in the same cycle → bvalid the next cycle with bresp = 0. A read of 0x04 returns 0xDEADBEEF, rresp = 0. WCOUNT (0x0C) reads 1.
- Write W 3 cycles before AW (0x00, data 0x12345678, wstrb = 0x5) → REG0 = 0x00340078. ctrl_out matches in the bvalid cycle.
- Write to 0x0C, then to 0x20, then to 0x02 → each gets bresp = 2, WCOUNT unchanged. Reads of 0x20 and 0x02 return rdata = 0, rresp = 2.
- Hold bready = 0 for 5 cycles after bvalid → bvalid and bresp stay stable, awready and wready stay 0. A new AW is accepted only after bready.
- In the same cycle: AR to 0x08 and the final write handshake of 0xAAAA5555 to 0x08 (old value 0x11) → rdata = 0x11; a following read of 0x08 returns 0xAAAA5555.
- Assert reset while in W_HAVE_ADDR and R_DATA → all outputs are 0 immediately, and registers read back 0 after release.
